// File: rtl/switch_pkg.sv
// Shared definitions for the switch frame reader: FSM state codes, frame byte offsets and
// the running XOR checksum step used when FRAME_CHECKSUM_EN is defined.
package switch_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHdr     = 3'd1;
  localparam logic [2:0] StLen     = 3'd2;
  localparam logic [2:0] StPayload = 3'd3;
  localparam logic [2:0] StChk     = 3'd4;

  localparam int unsigned HdrIdx = 0;
  localparam int unsigned LenIdx = 1;

  // Wide enough for any sensible DATA_WIDTH; callers zero-extend.
  localparam int unsigned CsumMaxWidth = 64;

  function automatic logic [CsumMaxWidth-1:0] csum_step(input logic [CsumMaxWidth-1:0] acc,
                                                        input logic [CsumMaxWidth-1:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/switch_frame_reader_if.sv
// FIFO read-side and payload stream signals of the switch frame reader.
// out_err exists only when FRAME_CHECKSUM_EN is defined.
interface switch_frame_reader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PORT_WIDTH = 2
);
  logic                  empty;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sof;
  logic                  out_eof;
  logic [PORT_WIDTH-1:0] out_port;
`ifdef FRAME_CHECKSUM_EN
  logic                  out_err;
`endif

  modport master (
    input  empty, read_data_in, out_ready,
`ifdef FRAME_CHECKSUM_EN
    output out_err,
`endif
    output read_enable, out_valid, out_data, out_sof, out_eof, out_port
  );

  modport slave (
    output empty, read_data_in, out_ready,
`ifdef FRAME_CHECKSUM_EN
    input  out_err,
`endif
    input  read_enable, out_valid, out_data, out_sof, out_eof, out_port
  );

endinterface

// File: rtl/switch_skid_buffer.sv
// Two-entry valid/ready buffer carrying {sof, eof, data}; hold_i keeps an eof entry at the
// head from being presented (used to wait for the checksum verdict).
module switch_skid_buffer #(
  parameter int unsigned DataWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic                 sof_i,
  input  logic                 eof_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 hold_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic                 sof_o,
  output logic                 eof_o,
  output logic [DataWidth-1:0] data_o,
  output logic [1:0]           count_o
);

  logic [DataWidth+1:0] mem_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           cnt_q;
  logic [DataWidth+1:0] head;
  logic                 pop;

  always_comb begin
    head    = mem_q[rd_ptr_q];
    sof_o   = head[DataWidth+1];
    eof_o   = head[DataWidth];
    data_o  = head[DataWidth-1:0];
    valid_o = (cnt_q != 2'd0) && !(hold_i && head[DataWidth]);
    pop     = valid_o && ready_i;
    count_o = cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {sof_i, eof_i, data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/switch_frame_reader.sv
// Drains header/length/payload bytes from the switch frame FIFO and emits payload beats.
// Define FRAME_CHECKSUM_EN for a trailing XOR checksum byte per frame and the out_err flag.
module switch_frame_reader
  import switch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PORT_WIDTH = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  reset,
  switch_frame_reader_if.master bus,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  logic [2:0]            state_q, state_d;
  logic                  rvalid_q;  // read_data_in carries a popped byte this cycle
  logic [PORT_WIDTH-1:0] port_q, port_d;
  logic [DATA_WIDTH-1:0] pop_rem_q, pop_rem_d, push_rem_q, push_rem_d;
  logic                  first_q, first_d;
  logic [CNT_WIDTH-1:0]  frame_q, frame_d, drop_q, drop_d;
  logic                  re, push, sk_pop, sk_valid, sk_sof, sk_eof, sk_hold;
  logic [1:0]            sk_cnt;
  logic [2:0]            occ_after;
  logic [PORT_WIDTH+DATA_WIDTH-1:0] sk_dout;
`ifdef FRAME_CHECKSUM_EN
  logic [CsumMaxWidth-1:0] csum_q, csum_d;
  logic                    chk_req_q, chk_req_d, chk_done_q, chk_done_d, err_q, err_d;

  assign sk_hold     = (state_q == StChk) && !chk_done_q;
  assign bus.out_err = err_q && sk_valid && sk_eof;
`else
  assign sk_hold = 1'b0;
`endif

  assign push      = rvalid_q && (state_q == StPayload);
  assign sk_pop    = sk_valid && bus.out_ready;
  // Occupancy once this cycle's push/pop settle; a new pop may only be issued if the word it
  // returns next cycle still fits.
  assign occ_after = {1'b0, sk_cnt} + {2'b0, push} - {2'b0, sk_pop};

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    pop_rem_d  = pop_rem_q;
    push_rem_d = push_rem_q;
    first_d    = first_q;
    drop_d     = drop_q;
    re         = 1'b0;
    frame_d    = (sk_pop && sk_eof) ? frame_q + CNT_WIDTH'(1) : frame_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d     = csum_q;
    chk_req_d  = chk_req_q;
    chk_done_d = chk_done_q;
    err_d      = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (!bus.empty) begin
          re      = 1'b1;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (rvalid_q) port_d = bus.read_data_in[PORT_WIDTH-1:0];
        if (!bus.empty) begin
          re      = 1'b1;
          state_d = StLen;
        end
      end
      StLen: begin
        if (bus.read_data_in == '0) begin
          drop_d  = drop_q + CNT_WIDTH'(1);
          state_d = StIdle;
        end else begin
          pop_rem_d  = bus.read_data_in;
          push_rem_d = bus.read_data_in;
          first_d    = 1'b1;
          state_d    = StPayload;
`ifdef FRAME_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      StPayload: begin
        if (!bus.empty && (pop_rem_q != '0) && (occ_after <= 3'd1)) begin
          re        = 1'b1;
          pop_rem_d = pop_rem_q - DATA_WIDTH'(1);
        end
        if (push) begin
          first_d    = 1'b0;
          push_rem_d = push_rem_q - DATA_WIDTH'(1);
`ifdef FRAME_CHECKSUM_EN
          csum_d     = csum_step(csum_q, CsumMaxWidth'(bus.read_data_in));
          if (push_rem_q == DATA_WIDTH'(1)) state_d = StChk;
`else
          if (push_rem_q == DATA_WIDTH'(1)) state_d = StIdle;
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      StChk: begin
        if (!chk_req_q && !bus.empty) begin
          re        = 1'b1;
          chk_req_d = 1'b1;
        end
        if (rvalid_q) begin
          err_d      = (csum_q != CsumMaxWidth'(bus.read_data_in));
          chk_done_d = 1'b1;
        end
        if (sk_pop && sk_eof) begin
          chk_req_d  = 1'b0;
          chk_done_d = 1'b0;
          state_d    = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rvalid_q   <= 1'b0;
      port_q     <= '0;
      pop_rem_q  <= '0;
      push_rem_q <= '0;
      first_q    <= 1'b0;
      frame_q    <= '0;
      drop_q     <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q     <= '0;
      chk_req_q  <= 1'b0;
      chk_done_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rvalid_q   <= re;
      port_q     <= port_d;
      pop_rem_q  <= pop_rem_d;
      push_rem_q <= push_rem_d;
      first_q    <= first_d;
      frame_q    <= frame_d;
      drop_q     <= drop_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q     <= csum_d;
      chk_req_q  <= chk_req_d;
      chk_done_q <= chk_done_d;
      err_q      <= err_d;
`endif
    end
  end

  switch_skid_buffer #(
    .DataWidth(PORT_WIDTH + DATA_WIDTH)
  ) u_skid (
    .clk_i  (rclk),
    .rst_i  (reset),
    .push_i (push),
    .sof_i  (first_q),
    .eof_i  (push_rem_q == DATA_WIDTH'(1)),
    .data_i ({port_q, bus.read_data_in}),
    .hold_i (sk_hold),
    .ready_i(bus.out_ready),
    .valid_o(sk_valid),
    .sof_o  (sk_sof),
    .eof_o  (sk_eof),
    .data_o (sk_dout),
    .count_o(sk_cnt)
  );

  // Reset must silence the pop request at once, not only after the next edge.
  assign bus.read_enable = re && !reset;
  assign bus.out_valid   = sk_valid;
  assign bus.out_sof     = sk_sof;
  assign bus.out_eof     = sk_eof;
  assign bus.out_data    = sk_dout[DATA_WIDTH-1:0];
  assign bus.out_port    = sk_dout[PORT_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign frame_count     = frame_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_switch_frame_reader.sv
// Self-checking bench for switch_frame_reader: a byte-queue FIFO model feeds the DUT and a
// scoreboard of expected payload beats is compared as beats transfer.
`timescale 1ns/1ps
module tb_switch_frame_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] frame_count, drop_count;

  switch_frame_reader_if #(.DATA_WIDTH(DW), .PORT_WIDTH(PW)) bus ();

  switch_frame_reader #(
    .DATA_WIDTH(DW),
    .PORT_WIDTH(PW),
    .CNT_WIDTH (CW)
  ) dut (
    .rclk       (clk),
    .reset      (rst),
    .bus        (bus),
    .frame_count(frame_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned re_viol = 0;
  int unsigned rd_total = 0;
  int unsigned pushed_total = 0;
  int unsigned exp_frames = 0;
  int unsigned exp_drops = 0;
  logic [7:0]  fifo_q [$];
  logic [7:0]  pay_q [$];
  logic [12:0] sb [$];  // {err, port, sof, eof, data}

  // FIFO model: a pop seen at the negedge returns its byte just after the next posedge.
  initial begin
    logic do_pop;
    bus.empty        = 1'b1;
    bus.read_data_in = '0;
    forever begin
      @(negedge clk);
      do_pop = bus.read_enable;
      if (bus.read_enable === 1'b1 && bus.empty === 1'b1) re_viol++;
      @(posedge clk);
      #1;
      if (do_pop === 1'b1 && fifo_q.size() != 0) begin
        bus.read_data_in = fifo_q.pop_front();
        rd_total++;
      end
      bus.empty = (fifo_q.size() == 0);
    end
  end

  task automatic push_frame(input logic [7:0] hdr, input bit bad);
    logic [7:0] x;
    int n;
    x = 8'h00;
    n = pay_q.size();
    fifo_q.push_back(hdr);
    fifo_q.push_back(8'(n));
    pushed_total += 2;
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(pay_q[i]);
      x ^= pay_q[i];
      pushed_total++;
      sb.push_back({bad, hdr[1:0], (i == 0), (i == n - 1), pay_q[i]});
    end
`ifdef FRAME_CHECKSUM_EN
    if (n != 0) begin
      fifo_q.push_back(bad ? ((x == 8'h00) ? 8'hFF : 8'h00) : x);
      pushed_total++;
    end
`endif
    if (n == 0) exp_drops++;
    else exp_frames++;
    pay_q.delete();
  endtask

  // Run until only 'left' beats remain expected, comparing each transferred beat.
  task automatic drain(input int left, input int budget, input bit toggle);
    int n;
    logic stalled;
    logic [11:0] held, cur;
    logic [12:0] e;
    n = 0;
    stalled = 1'b0;
    held = '0;
    while (sb.size() > left && n < budget) begin
      @(negedge clk);
      cur = {bus.out_port, bus.out_sof, bus.out_eof, bus.out_data};
      if (stalled) begin
        checks++;
        if (bus.out_valid !== 1'b1 || cur !== held) begin
          failures++;
          $display("FAIL stall_hold: got valid=%b beat=%h, want valid=1 beat=%h",
                   bus.out_valid, cur, held);
        end
      end
      stalled = 1'b0;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (cur !== e[11:0]) begin
          failures++;
          $display("FAIL beat: got port=%h sof=%b eof=%b data=%h, want port=%h sof=%b eof=%b data=%h",
                   cur[11:10], cur[9], cur[8], cur[7:0], e[11:10], e[9], e[8], e[7:0]);
        end
`ifdef FRAME_CHECKSUM_EN
        if (e[8]) begin
          checks++;
          if (bus.out_err !== e[12]) begin
            failures++;
            $display("FAIL out_err: got %b, want %b", bus.out_err, e[12]);
          end
        end
`endif
      end else if (bus.out_valid === 1'b1) begin
        stalled = 1'b1;
        held = cur;
      end
      @(posedge clk);
      #1;
      if (toggle) bus.out_ready = ~bus.out_ready;
      n++;
    end
    if (sb.size() > left) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d beats outstanding, want %0d", sb.size(), left);
    end
  endtask

  task automatic expect_idle(input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL idle_valid: got %0d valid cycles, want 0", seen);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sof !== 1'b0 || bus.out_eof !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got valid=%b sof=%b eof=%b, want 0 0 0",
               bus.out_valid, bus.out_sof, bus.out_eof);
    end
    checks++;
    if (bus.out_data !== 8'h00 || bus.out_port !== 2'd0) begin
      failures++;
      $display("FAIL reset_data: got data=%h port=%h, want 00 0", bus.out_data, bus.out_port);
    end
    checks++;
    if (frame_count !== 16'd0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts: got frames=%0d drops=%0d, want 0 0", frame_count, drop_count);
    end
    checks++;
    if (bus.read_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_read_enable: got %b, want 0", bus.read_enable);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    pay_q = '{8'hA1, 8'hA2, 8'hA3};
    push_frame(8'h02, 1'b0);
    drain(0, 100, 1'b0);
    checks++;
    if (frame_count !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL single_frames: got %0d, want %0d", frame_count, exp_frames);
    end
    expect_idle(6);
    checks++;
    if (rd_total !== pushed_total || bus.read_enable !== 1'b0) begin
      failures++;
      $display("FAIL single_reads: got reads=%0d re=%b, want reads=%0d re=0",
               rd_total, bus.read_enable, pushed_total);
    end
  endtask

  task automatic test_back_to_back();
    pay_q = '{8'h55};
    push_frame(8'h01, 1'b0);
    pay_q = '{8'h10, 8'h20};
    push_frame(8'h03, 1'b0);
    drain(0, 100, 1'b0);
    checks++;
    if (frame_count !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL b2b_frames: got %0d, want %0d", frame_count, exp_frames);
    end
    expect_idle(4);
  endtask

  task automatic test_drop();
    pay_q.delete();
    push_frame(8'h01, 1'b0);
    pay_q = '{8'h77};
    push_frame(8'hFE, 1'b0);
    drain(0, 100, 1'b0);
    checks++;
    if (drop_count !== 16'(exp_drops) || frame_count !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL drop_counts: got drops=%0d frames=%0d, want drops=%0d frames=%0d",
               drop_count, frame_count, exp_drops, exp_frames);
    end
    expect_idle(4);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) pay_q.push_back(8'hC0 + 8'(i));
    push_frame(8'h00, 1'b0);
    drain(0, 200, 1'b1);
    bus.out_ready = 1'b1;
    checks++;
    if (frame_count !== 16'(exp_frames) || rd_total !== pushed_total) begin
      failures++;
      $display("FAIL bp_counts: got frames=%0d reads=%0d, want frames=%0d reads=%0d",
               frame_count, rd_total, exp_frames, pushed_total);
    end
    checks++;
    if (re_viol !== 0) begin
      failures++;
      $display("FAIL read_when_empty: got %0d, want 0", re_viol);
    end
  endtask

  task automatic test_empty_stall();
    logic [7:0] held_q [$];
    int nhold;
    int seen;
    pay_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    push_frame(8'h02, 1'b0);
    nhold = 2;
`ifdef FRAME_CHECKSUM_EN
    nhold = 3;
`endif
    for (int i = 0; i < nhold; i++) held_q.push_front(fifo_q.pop_back());
    drain(2, 100, 1'b0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL stall_output: got %0d valid cycles while empty, want 0", seen);
    end
    while (held_q.size() != 0) fifo_q.push_back(held_q.pop_front());
    drain(0, 100, 1'b0);
    checks++;
    if (frame_count !== 16'(exp_frames) || re_viol !== 0) begin
      failures++;
      $display("FAIL stall_resume: got frames=%0d viol=%0d, want frames=%0d viol=0",
               frame_count, re_viol, exp_frames);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) pay_q.push_back(8'h60 + 8'(i));
    bus.out_ready = 1'b0;
    push_frame(8'h03, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || frame_count == 16'd0) begin
      failures++;
      $display("FAIL midframe_pre: got valid=%b frames=%0d, want valid=1 frames>0",
               bus.out_valid, frame_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_port !== 2'd0 ||
        bus.out_sof !== 1'b0 || bus.out_eof !== 1'b0) begin
      failures++;
      $display("FAIL midframe_outputs: got valid=%b data=%h port=%h sof=%b eof=%b, want all 0",
               bus.out_valid, bus.out_data, bus.out_port, bus.out_sof, bus.out_eof);
    end
    checks++;
    if (frame_count !== 16'd0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL midframe_counts: got frames=%0d drops=%0d, want 0 0", frame_count, drop_count);
    end
    checks++;
    if (bus.read_enable !== 1'b0 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL midframe_read_enable: got re=%b empty=%b, want re=0 empty=0",
               bus.read_enable, bus.empty);
    end
    fifo_q.delete();
    sb.delete();
    exp_frames = 0;
    exp_drops = 0;
    repeat (2) @(posedge clk);
    #1;
    rd_total = 0;
    pushed_total = 0;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    pay_q = '{8'h99};
    push_frame(8'h01, 1'b0);
    drain(0, 100, 1'b0);
    checks++;
    if (frame_count !== 16'd1 || rd_total !== pushed_total) begin
      failures++;
      $display("FAIL post_reset_frame: got frames=%0d reads=%0d, want frames=1 reads=%0d",
               frame_count, rd_total, pushed_total);
    end
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    pay_q = '{8'h01, 8'h02};
    push_frame(8'h02, 1'b0);
    pay_q = '{8'h01, 8'h02};
    push_frame(8'h02, 1'b1);
    drain(0, 100, 1'b0);
    checks++;
    if (frame_count !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL csum_frames: got %0d, want %0d", frame_count, exp_frames);
    end
  endtask
`endif

  initial begin
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_backpressure();
    test_empty_stall();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/switch_frame_reader.md
Name: switch_frame_reader

Overview:
- Read-side consumer of the switch's frame FIFO, in the read clock domain.
- Drains bytes through the FIFO's `empty` / `read_enable` / `read_data` interface and parses them into frames.
- Emits frame payload on a valid/ready stream with start-of-frame, end-of-frame and destination-port tags.
- Counterpart of the ingress writer that packs frames into the FIFO.

Parameters:
- DATA_WIDTH, 8, FIFO word and output data width.
- PORT_WIDTH, 2, width of destination port field taken from header byte [PORT_WIDTH-1:0].
- CNT_WIDTH, 16, width of frame/drop statistics counters.

Ports:
- rclk  in  1  sole clock (FIFO read clock).
- reset  in  1  asynchronous, active-high reset.
- empty  in  1  FIFO empty flag.
- read_enable  out  1  FIFO pop request.
- read_data_in  in  DATA_WIDTH  FIFO read data, valid the cycle after read_enable.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  payload byte.
- out_sof  out  1  first payload byte of frame.
- out_eof  out  1  last payload byte of frame.
- out_port  out  PORT_WIDTH  destination port, stable for whole frame.
- frame_count  out  CNT_WIDTH  frames fully emitted.
- drop_count  out  CNT_WIDTH  frames dropped (zero length).

Behaviour:
- Clock and reset: one clock, rclk; reset is asynchronous and active-high.
- Reset values: all outputs 0; state = IDLE; skid buffer empty; counters 0.
- Reset mid-frame aborts the frame; no resynchronisation to the FIFO is attempted.
- Frame format in FIFO: header byte (port in low PORT_WIDTH bits, upper bits ignored), then length byte L, then L payload bytes.
- FIFO read timing: read_enable asserted in cycle N returns data on read_data_in in cycle N+1.
- read_enable is asserted only when `!empty`. It is never asserted while `empty` is high.
- States:
  - IDLE: pop the header when `!empty`, go to HDR.
  - HDR: wait for header data; latch out_port; pop length when `!empty`, go to LEN.
  - LEN: latch L.
    - L == 0: drop_count += 1, return to IDLE.
    - Otherwise: go to PAYLOAD with remaining = L.
  - PAYLOAD: pop payload bytes while `!empty`, remaining pops > 0, and the skid buffer has space counting the in-flight word. After the last pop, wait for the last word to enter the skid buffer, then go to IDLE (CHK when the feature is enabled).
- Header and length bytes are never presented on the output.
- Throughput: with out_ready held high and the FIFO non-empty, one payload byte per cycle after a 2-cycle header/length overhead.
- Output stream:
  - out_data/out_sof/out_eof are held stable while `out_valid && !out_ready`.
  - Transfer occurs on `out_valid && out_ready`.
  - out_sof is set on payload index 0 and out_eof on index L-1; both are set when L == 1.
- frame_count increments on the cycle the eof beat transfers.
- Counters wrap modulo 2^CNT_WIDTH.
- Simultaneous events:
  - The next header may be popped in the same cycle the eof beat transfers, if the FIFO is non-empty.
  - A skid push and pop in the same cycle keeps occupancy constant.
- `empty` rising mid-frame: stall pops and resume when `!empty`. No timeout.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- Defined:
  - Each frame carries one trailing checksum byte equal to the XOR of all payload bytes.
  - CHK state pops and compares it.
  - Port out_err (1 bit) is valid with the eof beat and is 1 on mismatch.
  - The eof beat is held in the skid buffer until the checksum has been compared.
- Not defined: no trailer byte, no CHK state, no out_err port.

Decomposition:
- Shared package switch_pkg holds:
  - state enum (IDLE, HDR, LEN, PAYLOAD, CHK);
  - frame byte-offset constants (HDR_IDX=0, LEN_IDX=1);
  - checksum function.
- Sub-module: switch_skid_buffer, a 2-entry valid/ready buffer carrying {sof, eof, data}.

Test Plan:
- Frame hdr=0x02, L=3, payload A1 A2 A3, out_ready=1 -> three beats, out_port=2, sof on A1, eof on A3, frame_count=1, no extra reads.
- Back-to-back frames L=1 (0x55) and L=2 (0x10 0x20) -> beat 0x55 with sof=eof=1, then 0x10 sof and 0x20 eof; frame_count=2.
- L=0 frame followed by L=1 frame (0x77) -> drop_count=1; only 0x77 emitted.
- out_ready toggled 1/0 every cycle over L=8 -> data held stable while stalled; all 8 bytes in order; read_enable never asserted with empty=1.
- empty forced high after 2 of 4 payload bytes for 5 cycles -> output pauses, resumes, eof on 4th byte.
- Reset asserted during PAYLOAD -> outputs and counters 0 immediately; state IDLE. With FRAME_CHECKSUM_EN: payload 01 02, checksum 03 -> out_err=0; checksum 00 -> out_err=1.
